rfile_param: RTL and testbench

Parametrised 2-read/1-write register file, the next generation of the CPU datapath's fixed 32x32 register file. Adds configurable width and depth, an optional hardwired zero register, same-cycle write-to-read bypass, asynchronous reset clearing, and a sequenced bulk-clear engine with busy/done handshake. Sits between instruction decode (read ports) and writeback (write port).

---
 rtl/rfile_param_if.sv | 28 ++
 rtl/rfile_param.sv | 114 +++++++++++
 tb/tb_rfile_param.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rfile_param_if.sv
// Register file access bundle: two read ports, one write port and the
// bulk-clear handshake. The master side is decode/writeback, the slave side
// is the register file itself.
interface rfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data_a, rd_data_b, clr_busy, clr_done
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
        output rd_data_a, rd_data_b, clr_busy, clr_done
    );
endinterface

// File: rtl/rfile_param.sv
// Parametrised 2-read/1-write register file with optional hardwired zero
// register, same-cycle write-to-read bypass and a sequenced bulk-clear
// engine that walks every entry once, one per clock, then pulses clr_done.
module rfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    rfile_param_if.slave  bus
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nx;
    logic              done_q;
    logic              done_nx;
    logic              clr_we;
    logic              wr_legal;
    logic [WIDTH-1:0]  mem [DEPTH];

    // An address names a real, writable/readable entry
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Read one port: out-of-range and the zero register read as 0,
    // a legal write to the same address this cycle is forwarded
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_live(a)) begin
            if (wr_legal && (bus.wr_addr == a)) v = bus.wr_data;
            else                                v = mem[a];
        end
        return v;
    endfunction

    assign wr_legal     = (state == IDLE) && bus.wr_en && addr_live(bus.wr_addr);
    assign bus.clr_busy = (state == CLEAR);
    assign bus.clr_done = done_q;

    // Clear-sequencer state, entry counter and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            done_q <= done_nx;
        end
    end

    // Next-state logic: IDLE waits for a request, CLEAR zeroes one entry per
    // cycle and returns to IDLE after the last entry with a one-cycle done
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        clr_we   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST_C) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + ONE_C;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Storage: reset wipes everything; writes only land in IDLE and the
    // clear engine only writes in CLEAR, so the two never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_legal) mem[bus.wr_addr] <= bus.wr_data;
            if (clr_we)   mem[cnt[ADDR_W-1:0]] <= '0;
        end
    end

    // Combinational read ports
    always_comb begin
        bus.rd_data_a = read_port(bus.rd_addr_a);
        bus.rd_data_b = read_port(bus.rd_addr_b);
    end

endmodule

// File: tb/tb_rfile_param.sv
// Bench for rfile_param: three instances (default, no zero register, and
// DEPTH=20) share one stimulus stream and are each compared every cycle
// against a behavioural model of the register file.
module tb_rfile_param;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;

    int tests_run;
    int tests_failed;

    rfile_param_if #(.WIDTH(32), .ADDR_W(5)) if_a ();
    rfile_param_if #(.WIDTH(32), .ADDR_W(5)) if_b ();
    rfile_param_if #(.WIDTH(32), .ADDR_W(5)) if_c ();

    rfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    rfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    rfile_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    // Fan the shared stimulus out to all three instances
    assign if_a.rd_addr_a = rd_addr_a;  assign if_b.rd_addr_a = rd_addr_a;  assign if_c.rd_addr_a = rd_addr_a;
    assign if_a.rd_addr_b = rd_addr_b;  assign if_b.rd_addr_b = rd_addr_b;  assign if_c.rd_addr_b = rd_addr_b;
    assign if_a.wr_en     = wr_en;      assign if_b.wr_en     = wr_en;      assign if_c.wr_en     = wr_en;
    assign if_a.wr_addr   = wr_addr;    assign if_b.wr_addr   = wr_addr;    assign if_c.wr_addr   = wr_addr;
    assign if_a.wr_data   = wr_data;    assign if_b.wr_data   = wr_data;    assign if_c.wr_data   = wr_data;
    assign if_a.clr_req   = clr_req;    assign if_b.clr_req   = clr_req;    assign if_c.clr_req   = clr_req;

    logic [31:0] obs_ra [3];
    logic [31:0] obs_rb [3];
    logic        obs_busy [3];
    logic        obs_done [3];

    assign obs_ra[0] = if_a.rd_data_a;  assign obs_rb[0] = if_a.rd_data_b;
    assign obs_ra[1] = if_b.rd_data_a;  assign obs_rb[1] = if_b.rd_data_b;
    assign obs_ra[2] = if_c.rd_data_a;  assign obs_rb[2] = if_c.rd_data_b;
    assign obs_busy[0] = if_a.clr_busy; assign obs_done[0] = if_a.clr_done;
    assign obs_busy[1] = if_b.clr_busy; assign obs_done[1] = if_b.clr_done;
    assign obs_busy[2] = if_c.clr_busy; assign obs_done[2] = if_c.clr_done;

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents plus "how many entries are still to be
    // wiped" for each instance
    logic [31:0] ref_mem [3][32];
    int          ref_left [3];
    bit          ref_done [3];
    int          cycle_no;

    function automatic int depth_of(input int i);
        return (i == 2) ? 20 : 32;
    endfunction

    function automatic bit zero_of(input int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit usable(input int i, input logic [4:0] a);
        return (int'(a) < depth_of(i)) && !(zero_of(i) && a == 5'd0);
    endfunction

    function automatic logic [31:0] ref_read(input int i, input logic [4:0] a);
        if (!usable(i, a)) return 32'h0;
        if (ref_left[i] == 0 && wr_en && wr_addr == a) return wr_data;
        return ref_mem[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 32; j++) ref_mem[i][j] = 32'h0;
            ref_left[i] = 0;
            ref_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int i = 0; i < 3; i++) begin
            bit finished;
            finished = 1'b0;
            if (ref_left[i] == 0) begin
                if (wr_en && usable(i, wr_addr)) ref_mem[i][wr_addr] = wr_data;
                if (clr_req) ref_left[i] = depth_of(i);
            end else begin
                ref_mem[i][depth_of(i) - ref_left[i]] = 32'h0;
                ref_left[i]--;
                if (ref_left[i] == 0) finished = 1'b1;
            end
            ref_done[i] = finished;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s cyc=%0d: got %h expected %h", tag, cycle_no, obs, exp);
        end
    endtask

    // Check all outputs of all instances in the low phase, then clock once
    task automatic applyStimulus();
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d.rd_a[%0d]", i, rd_addr_a), obs_ra[i], ref_read(i, rd_addr_a));
            checkOutput($sformatf("u%0d.rd_b[%0d]", i, rd_addr_b), obs_rb[i], ref_read(i, rd_addr_b));
            checkOutput($sformatf("u%0d.busy", i), {31'h0, obs_busy[i]}, {31'h0, ref_left[i] != 0});
            checkOutput($sformatf("u%0d.done", i), {31'h0, obs_done[i]}, {31'h0, ref_done[i]});
        end
        @(posedge clk);
        model_edge();
        cycle_no++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'h0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = d;
        rd_addr_a = 5'(a);
        rd_addr_b = 5'(a);
        applyStimulus();
        wr_en = 1'b0;
    endtask

    task automatic sweep();
        idle_inputs();
        for (int a = 0; a < 32; a += 2) begin
            rd_addr_a = 5'(a);
            rd_addr_b = 5'(a + 1);
            applyStimulus();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cycle_no     = 0;
        rst_n        = 1'b0;
        rd_addr_a    = 5'd0;
        rd_addr_b    = 5'd0;
        idle_inputs();
        model_reset();
        @(negedge clk);

        // Reset state, then release mid-cycle
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        sweep();

        // Zero register: write all-ones to entry 0
        do_write(0, 32'hFFFF_FFFF);
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        applyStimulus();

        // Bypass on both ports, then persistence through storage
        do_write(7, 32'hDEAD_BEEF);
        rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        applyStimulus();

        // Out-of-range for the DEPTH=20 instance
        do_write(25, 32'h0000_1234);
        sweep();

        // Fill 1..31 with value = address, then bulk clear
        for (int a = 1; a < 32; a++) do_write(a, 32'(a));
        clr_req = 1'b1;
        rd_addr_a = 5'd31; rd_addr_b = 5'd5;
        applyStimulus();
        clr_req = 1'b0;
        for (int k = 0; k < 36; k++) begin
            clr_req   = (k >= 2 && k <= 5);
            wr_en     = (k == 3);
            wr_addr   = 5'd5;
            wr_data   = 32'h0000_0055;
            rd_addr_a = 5'd31;
            rd_addr_b = 5'(k % 32);
            applyStimulus();
        end
        sweep();

        // Write and clear request in the same cycle
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_00A5; clr_req = 1'b1;
        rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        applyStimulus();
        idle_inputs();
        for (int k = 0; k < 34; k++) applyStimulus();

        // Back-to-back clear: request held through the done cycle
        clr_req = 1'b1;
        for (int k = 0; k < 34; k++) applyStimulus();
        clr_req = 1'b0;
        for (int k = 0; k < 34; k++) applyStimulus();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            clr_req   = ($urandom_range(0, 59) == 0);
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            applyStimulus();
        end
        idle_inputs();
        for (int k = 0; k < 34; k++) applyStimulus();

        // Reset in the middle of a clear
        for (int a = 1; a < 32; a++) do_write(a, 32'hC000_0000 | 32'(a));
        clr_req = 1'b1;
        applyStimulus();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd_addr_a = 5'd31; rd_addr_b = 5'd19;
            applyStimulus();
        end
        rst_n = 1'b0;
        model_reset();
        rd_addr_a = 5'd31; rd_addr_b = 5'd19;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        sweep();

        // Full-length clear after the reset
        for (int a = 1; a < 32; a++) do_write(a, ~32'(a));
        clr_req = 1'b1;
        applyStimulus();
        clr_req = 1'b0;
        for (int k = 0; k < 34; k++) begin
            rd_addr_a = 5'(k % 32); rd_addr_b = 5'd31;
            applyStimulus();
        end
        sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
